// File: rtl/div_sequencer_pkg.sv
// Shared encodings for the divide sequencer.
//   ALU_DIV/DIVU/REM/REMU : decode op codes for the RV32M divide family
//   ds_state_t            : sequencer FSM states
package div_sequencer_pkg;

    localparam logic [4:0] ALU_DIV  = 5'b01100;
    localparam logic [4:0] ALU_DIVU = 5'b01101;
    localparam logic [4:0] ALU_REM  = 5'b01110;
    localparam logic [4:0] ALU_REMU = 5'b01111;

    typedef enum logic [1:0] {
        DS_IDLE = 2'd0,
        DS_BUSY = 2'd1,
        DS_DONE = 2'd2
    } ds_state_t;

endpackage

// File: rtl/div_step.sv
// One iteration of radix-2 restoring division (combinational).
// Ports:
//   rem_in, quo_in : partial remainder and quotient/dividend shift register
//   divisor        : absolute divisor value
//   rem_out        : partial remainder after shift and trial subtract
//   quo_out        : shift register with the new quotient bit in bit 0
module div_step #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] rem_in,
    input  logic [DATA_W-1:0] quo_in,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] rem_out,
    output logic [DATA_W-1:0] quo_out
);

    // One extra bit: rem_in < divisor, so 2*rem_in+1 can exceed DATA_W bits.
    logic [DATA_W:0] shifted;
    logic            fits;

    assign shifted = {rem_in, quo_in[DATA_W-1]};
    assign fits    = (shifted >= {1'b0, divisor});

    always_comb begin
        rem_out = shifted[DATA_W-1:0];
        if (fits) begin
            rem_out = shifted[DATA_W-1:0] - divisor;
        end
        quo_out = {quo_in[DATA_W-2:0], fits};
    end

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle DIV/DIVU/REM/REMU sequencer beside the EX-stage ALU.
// Holds the pipeline via stall while a restoring division iterates, then
// presents the quotient or remainder for one cycle with done.
// Ports:
//   clk, reset          : clock, asynchronous active-low reset
//   start, alu_op       : valid EX instruction and its decoded ALU op
//   operand1, operand2  : dividend, divisor
//   flush               : aborts any operation in EX
//   stall, busy, done   : pipeline hold, FSM not idle, result-valid pulse
//   result              : registered quotient or remainder
// Build option: DIV_SEQ_RESULT_REUSE_EN returns a cached result when a
// divide repeats the operands and signedness of the last completed one.
//
//   state   | meaning
//   --------+---------------------------------------------------
//   DS_IDLE | waiting for a divide op; launches on is_div & ~flush
//   DS_BUSY | one quotient bit per cycle, DATA_W cycles
//   DS_DONE | result valid, done pulses, pipeline released
module div_sequencer
    import div_sequencer_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [4:0]        alu_op,
    input  logic [DATA_W-1:0] operand1,
    input  logic [DATA_W-1:0] operand2,
    input  logic              flush,
    output logic              stall,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result
);

    localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    ds_state_t         state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] rem_q, quo_q, div_q;
    logic              rem_sel, neg_q, neg_r;

    logic              is_div, op_signed, op_rem, div_zero, sgn_ovf, reuse_hit;
    logic [DATA_W-1:0] abs1, abs2;
    logic [DATA_W-1:0] step_rem, step_quo, quo_fix, rem_fix;
    logic              launch, finish, stall_raw;

    assign is_div    = start & (alu_op[4:3] == 2'b01) & alu_op[2];
    assign op_signed = ~alu_op[0];
    assign op_rem    = alu_op[1];
    assign div_zero  = (operand2 == '0);
    assign sgn_ovf   = op_signed & (operand1 == MIN_NEG) & (operand2 == '1);
    assign abs1      = (op_signed & operand1[DATA_W-1]) ? -operand1 : operand1;
    assign abs2      = (op_signed & operand2[DATA_W-1]) ? -operand2 : operand2;

`ifdef DIV_SEQ_RESULT_REUSE_EN
    logic [DATA_W-1:0] op1_q, op2_q, saved_op1, saved_op2, saved_quo, saved_rem;
    logic              signed_q, saved_signed, saved_valid;

    assign reuse_hit = saved_valid & (operand1 == saved_op1) &
                       (operand2 == saved_op2) & (op_signed == saved_signed);
`else
    assign reuse_hit = 1'b0;
`endif

    div_step #(.DATA_W(DATA_W)) u_div_step (
        .rem_in  (rem_q),
        .quo_in  (quo_q),
        .divisor (div_q),
        .rem_out (step_rem),
        .quo_out (step_quo)
    );

    // Final iteration output goes straight through sign fix-up into result.
    assign quo_fix = neg_q ? -step_quo : step_quo;
    assign rem_fix = neg_r ? -step_rem : step_rem;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= DS_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        stall_raw = 1'b0;
        done      = 1'b0;
        launch    = 1'b0;
        finish    = 1'b0;
        case (state)
            DS_IDLE: begin
                if (is_div && !flush) begin
                    stall_raw = 1'b1;
                    launch    = 1'b1;
                    if (div_zero || sgn_ovf || reuse_hit) begin
                        state_nxt = DS_DONE;
                    end else begin
                        state_nxt = DS_BUSY;
                    end
                end
            end
            DS_BUSY: begin
                if (flush) begin
                    state_nxt = DS_IDLE;
                end else begin
                    stall_raw = 1'b1;
                    if (cnt == '0) begin
                        state_nxt = DS_DONE;
                        finish    = 1'b1;
                    end
                end
            end
            DS_DONE: begin
                state_nxt = DS_IDLE;
                done      = ~flush;
            end
            default: state_nxt = DS_IDLE;
        endcase
    end

    // Gated so a start held during reset cannot freeze the pipeline.
    assign stall = stall_raw & reset;
    assign busy  = (state != DS_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            div_q   <= '0;
            rem_sel <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            result  <= '0;
        end else if (launch) begin
            cnt     <= CNT_W'(DATA_W - 1);
            rem_q   <= '0;
            quo_q   <= abs1;
            div_q   <= abs2;
            rem_sel <= op_rem;
            neg_q   <= op_signed & (operand1[DATA_W-1] ^ operand2[DATA_W-1]);
            neg_r   <= op_signed & operand1[DATA_W-1];
`ifdef DIV_SEQ_RESULT_REUSE_EN
            if (reuse_hit) begin
                result <= op_rem ? saved_rem : saved_quo;
            end else
`endif
            if (div_zero) begin
                result <= op_rem ? operand1 : '1;
            end else if (sgn_ovf) begin
                result <= op_rem ? '0 : MIN_NEG;
            end
        end else if (state == DS_BUSY) begin
            rem_q <= step_rem;
            quo_q <= step_quo;
            if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (finish) begin
                result <= rem_sel ? rem_fix : quo_fix;
            end
        end
    end

`ifdef DIV_SEQ_RESULT_REUSE_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op1_q        <= '0;
            op2_q        <= '0;
            signed_q     <= 1'b0;
            saved_op1    <= '0;
            saved_op2    <= '0;
            saved_quo    <= '0;
            saved_rem    <= '0;
            saved_signed <= 1'b0;
            saved_valid  <= 1'b0;
        end else begin
            if (launch) begin
                op1_q    <= operand1;
                op2_q    <= operand2;
                signed_q <= op_signed;
            end
            if (flush) begin
                saved_valid <= 1'b0;
            end else if (finish) begin
                saved_valid  <= 1'b1;
                saved_op1    <= op1_q;
                saved_op2    <= op2_q;
                saved_signed <= signed_q;
                saved_quo    <= quo_fix;
                saved_rem    <= rem_fix;
            end
        end
    end
`endif

endmodule

// File: doc/div_sequencer.md
Name: div_sequencer

Overview:
- Multi-cycle controller and iterative datapath for the RV32M divide and remainder instructions: DIV, DIVU, REM and REMU.
- Sits beside the EX-stage ALU.
- Recognises divide ops from the alu_op code produced by decode and holds the pipeline through stall while running a radix-2 restoring division.
- Returns the quotient or remainder in a one-cycle done slot.
- MUL* ops stay single-cycle in the ALU and are ignored by this block.

Parameters:
DATA_W, 32, operand/result width; the iteration count equals DATA_W.
CNT_W, 5, iteration counter width; must satisfy 2**CNT_W >= DATA_W.

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  asynchronous, active-low reset (reset==0 clears all state)
start  input  1  EX holds a valid, non-bubble instruction
alu_op  input  5  ALU operation code from decode; a divide is alu_op[4:3]==2'b01 && alu_op[2]==1
operand1  input  DATA_W  dividend (rs1 after forwarding)
operand2  input  DATA_W  divisor (rs2 after forwarding)
flush  input  1  branch/jump flush of EX; aborts any operation
stall  output  1  freezes PC, IF/ID and ID/EX registers
busy  output  1  FSM not IDLE
done  output  1  result valid this cycle (one-cycle pulse)
result  output  DATA_W  quotient (alu_op[1]==0) or remainder (alu_op[1]==1)

Behaviour:
- Op decode, with is_div = start & alu_op[4:3]==01 & alu_op[2]:
  - alu_op[0]==0 selects signed; alu_op[0]==1 selects unsigned.
  - alu_op[1] selects the remainder.
- FSM states: IDLE, BUSY, DONE.
- Reset: state=IDLE, counter=0, quotient/remainder/divisor registers=0, done=0, busy=0, result=0. Reset is honoured mid-operation: any operation in flight is abandoned.
- IDLE, is_div & ~flush, cycle T:
  - stall=1 combinationally in T.
  - Latch the op, the sign flags and the absolute operand values.
  - Special case divisor==0: go to DONE; quotient=all ones, remainder=operand1.
  - Special case signed overflow (operand1==0x80000000, operand2==0xFFFFFFFF): go to DONE; quotient=0x80000000, remainder=0.
  - Otherwise: go to BUSY, counter=DATA_W-1.
- BUSY:
  - Per cycle: shift {rem,quo} left by 1, trial-subtract the divisor; if the result is non-negative, keep it and set quo[0].
  - counter decrements each cycle; at counter==0 go to DONE.
  - stall=1 throughout.
  - Exactly DATA_W BUSY cycles (T+1..T+32). Normal latency is done at T+33; special cases give done at T+1.
- DONE:
  - done=1, stall=0, result valid.
  - Sign fix-up on the signed path: quotient negated if the operand signs differ; remainder takes the sign of the dividend.
  - The pipeline advances at the end of this cycle.
  - Next state is IDLE unconditionally; start is ignored in DONE, so the same instruction cannot retrigger.
- flush in BUSY or DONE: go to IDLE next cycle, done=0, stall deasserted that cycle.
- flush in IDLE overrides start: no operation begins.
- Non-divide ops: no state change, stall=0, done=0.
- result is registered and holds its last value outside DONE.

Optional Feature:
- Macro DIV_SEQ_RESULT_REUSE_EN.
- When defined:
  - The block keeps the last completed operand1, operand2, signedness, quotient and remainder, plus a valid bit.
  - A new divide in IDLE with matching operands and signedness (either DIV/REM flavour) goes directly to DONE, returning the stored quotient or remainder; done at T+1.
  - The valid bit is cleared by reset and by flush.
- When undefined: every divide iterates fully, apart from the special cases.

Decomposition:
- Shared encodings file:
  - Constants ALU_DIV=5'b01100, ALU_DIVU=5'b01101, ALU_REM=5'b01110, ALU_REMU=5'b01111.
  - FSM state localparams DS_IDLE, DS_BUSY, DS_DONE.
- One natural sub-module, div_step: a combinational single-iteration shift/trial-subtract taking rem_in, quo_in and divisor, producing rem_out and quo_out.
- The FSM, counter and sign handling stay in div_sequencer.

Test Plan:
- DIV 100/7: start with op 01100 at T -> stall high T..T+32, done at T+33, result=14; REM on the same operands -> result=2.
- DIV -7/2 (0xFFFFFFF9, 2) -> result 0xFFFFFFFD (-3); REM -> result 0xFFFFFFFF (-1); DIVU on the same operands -> result 0x7FFFFFFC.
- DIVU 5/0 -> done at T+1, result 0xFFFFFFFF; REMU 5/0 -> result 5; DIV 0x80000000/0xFFFFFFFF -> result 0x80000000, done at T+1.
- Flush at T+10 of a DIV -> busy=0 and stall=0 from T+11, no done pulse; a following DIV completes normally.
- reset=0 at T+5 of a DIV -> outputs return to reset values immediately; ADD/MUL ops with start=1 -> stall stays 0.
- With DIV_SEQ_RESULT_REUSE_EN: DIV 100/7, then REM 100/7 -> the second done at T+1 with result=2; without the macro the second op takes 33 cycles.
